dsp_wdata_router: RTL
=====================

# dsp_wdata_router

Write-data dispatcher for the AXI4 interconnect, one per master port. It routes each W burst to the slave chosen by its AW transaction, using an internal route FIFO of outstanding AW decisions. Up to ROUTE_DEPTH bursts can be queued, and W beats may arrive before their AW. A 2-entry input buffer gives registered ready and full throughput. Sits between the master-side W port and the per-slave W arbitration.

## Interface
- SLV_AMT, 2, number of slave ports (≥2)
- DATA_WIDTH, 32, W data width
- LEN_W, 8, AWLEN width
- ROUTE_DEPTH, 4, route FIFO entries (power of 2, ≥2)
- SLV_ID_W, $clog2(SLV_AMT), slave ID width
- ACLK_i  in  1  clock; one clock, all logic on rising edge
- ARESETn_i  in  1  reset, asynchronous, active-low
- m_WDATA_i  in  DATA_WIDTH  master write data
- m_WLAST_i  in  1  last beat of burst
- m_WVALID_i  in  1  master beat valid
- m_WREADY_o  out  1  beat accepted when m_WVALID_i & m_WREADY_o
- dsp_AW_push_i  in  1  AW accepted; push route entry
- dsp_AW_slv_id_i  in  SLV_ID_W  target slave of pushed AW
- dsp_AW_len_i  in  LEN_W  AWLEN of pushed AW (beats−1)
- dsp_AW_full_o  out  1  route FIFO full; AW dispatcher must not push
- sa_WDATA_o  out  DATA_WIDTH*SLV_AMT  head beat data, same on every slot
- sa_WLAST_o  out  SLV_AMT  head beat WLAST, same on every slot
- sa_WVALID_o  out  SLV_AMT  one-hot valid to routed slave only
- sa_WREADY_i  in  SLV_AMT  per-slave ready
- w_len_err_o  out  1  burst-length mismatch pulse (see Configuration)

## Operation
- Route FIFO stores {slv_id, len}. A push writes when dsp_AW_push_i=1 and it is not full. A push while full is dropped; the bench flags it as a protocol error.
- W buffer is a 2-entry FIFO of {WDATA, WLAST}.
  - m_WREADY_o = (wcount != 2), derived from registers only.
  - There is no combinational path from sa_WREADY_i or the route state to m_WREADY_o.
- Forwarding condition: W buffer non-empty and route FIFO non-empty.
  - If head slv_id < SLV_AMT: sa_WVALID_o[slv_id]=1 and all other bits are 0. The beat is handshaked when sa_WREADY_i[slv_id]=1.
  - If head slv_id ≥ SLV_AMT (decode-error sink): all sa_WVALID_o are 0. The beat is consumed internally, one per cycle.
- Handshake pops the W buffer. A handshake of a beat with WLAST=1 also pops the route FIFO.
- The route FIFO head advances on the edge after the WLAST handshake. Back-to-back bursts to different slaves therefore need no idle cycle.
- Simultaneous push and pop on either FIFO: both occur and the count is unchanged. Route FIFO pointers wrap modulo ROUTE_DEPTH.
- With no route entry, at most 2 beats are buffered, then m_WREADY_o=0.

## Timing
- Reset values: m_WREADY_o=1, dsp_AW_full_o=0, sa_WVALID_o=0, sa_WLAST_o=0, sa_WDATA_o=0, w_len_err_o=0. Both FIFOs are empty and the beat counter is 0.
- Latency: a beat accepted at edge N is presented at sa_* during cycle N+1, provided a route entry exists.
- A route entry pushed at edge N is usable in cycle N+1.
- Throughput is 1 beat/cycle sustained with sa_WREADY_i held high.
- sa_WVALID_o, once asserted, stays asserted with stable data until handshake. This holds because the head is unchanged until pop.
- Reset mid-burst clears all state immediately. Partial bursts are discarded.

## Configuration
- DSP_W_LEN_CHK_EN defined:
  - An LEN_W-bit beat counter increments on each handshake and clears on the WLAST handshake.
  - w_len_err_o pulses high for 1 cycle, on the edge after the handshake, when either:
    - WLAST=1 and counter≠len, or
    - WLAST=0 and counter==len.
  - Routing is unaffected; the route FIFO still pops only on WLAST.
- DSP_W_LEN_CHK_EN not defined:
  - len is not stored and the counter is absent.
  - dsp_AW_len_i is ignored and w_len_err_o is tied 0.

## Test plan
- Reset, then push id=1/len=3 and send 4 beats 0xA0..0xA3 with WLAST on 0xA3 and ready high: sa_WVALID_o=2'b10 for 4 consecutive cycles, data in order, route FIFO empty afterwards, w_len_err_o=0.
- Send 3 beats with no AW pushed: m_WREADY_o drops after 2 beats accepted. After push id=0/len=2, all 3 beats reach slave 0 and m_WREADY_o returns to 1.
- Push id=0/len=0, then id=1/len=1, with ready high: beats go to slave 0 then slave 1 with no idle cycle between them.
- Push 4 entries (ROUTE_DEPTH=4): dsp_AW_full_o=1. Pop one burst while pushing in the same cycle: full stays 1 and the count is unchanged.
- Hold sa_WREADY_i[1]=0 for 5 cycles mid-burst: sa_WVALID_o[1] stays 1, data stable, m_WREADY_o=0 once the buffer holds 2 beats.
- With DSP_W_LEN_CHK_EN: len=3 but WLAST on beat 2 gives a single-cycle w_len_err_o pulse and the route still pops. With SLV_AMT=3 and id=3 pushed: beats are sunk and no sa_WVALID_o is asserted.

Source files
------------

// File: rtl/dsp_wdata_router.sv
// W-channel dispatcher: steers each write burst to the slave picked by its AW via a route FIFO.
// Optional burst-length checker enabled by defining DSP_W_LEN_CHK_EN.
module dsp_wdata_router #(
  parameter int SLV_AMT     = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_W       = 8,
  parameter int ROUTE_DEPTH = 4,
  parameter int SLV_ID_W    = $clog2(SLV_AMT)
) (
  input  logic                          ACLK_i,
  input  logic                          ARESETn_i,
  input  logic [DATA_WIDTH-1:0]         m_WDATA_i,
  input  logic                          m_WLAST_i,
  input  logic                          m_WVALID_i,
  output logic                          m_WREADY_o,
  input  logic                          dsp_AW_push_i,
  input  logic [SLV_ID_W-1:0]           dsp_AW_slv_id_i,
  input  logic [LEN_W-1:0]              dsp_AW_len_i,
  output logic                          dsp_AW_full_o,
  output logic [DATA_WIDTH*SLV_AMT-1:0] sa_WDATA_o,
  output logic [SLV_AMT-1:0]            sa_WLAST_o,
  output logic [SLV_AMT-1:0]            sa_WVALID_o,
  input  logic [SLV_AMT-1:0]            sa_WREADY_i,
  output logic                          w_len_err_o
);

  localparam int PTR_W = $clog2(ROUTE_DEPTH);
  localparam logic [SLV_ID_W:0] SLV_AMT_L = SLV_AMT[SLV_ID_W:0];

  logic [DATA_WIDTH-1:0] r_wb_data [2];
  logic [1:0]            r_wb_last;
  logic                  r_wb_rd;
  logic                  r_wb_wr;
  logic [1:0]            r_wb_cnt;

  logic [SLV_ID_W-1:0]   r_rt_id [ROUTE_DEPTH];
  logic [PTR_W-1:0]      r_rt_rd;
  logic [PTR_W-1:0]      r_rt_wr;
  logic [PTR_W:0]        r_rt_cnt;

  logic                  w_wb_push;
  logic                  w_hs;
  logic                  w_fwd;
  logic                  w_in_range;
  logic                  w_slv_rdy;
  logic                  w_rt_pop;
  logic                  w_rt_push;
  logic [SLV_AMT-1:0]    w_sel;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_head_last;
  logic [SLV_ID_W-1:0]   w_head_id;

  assign m_WREADY_o    = (r_wb_cnt != 2'd2);
  assign dsp_AW_full_o = (r_rt_cnt == (PTR_W+1)'(ROUTE_DEPTH));

  assign w_head_data = r_wb_data[r_wb_rd];
  assign w_head_last = r_wb_last[r_wb_rd];
  assign w_head_id   = r_rt_id[r_rt_rd];

  assign w_wb_push  = m_WVALID_i & m_WREADY_o;
  assign w_fwd      = (r_wb_cnt != 2'd0) && (r_rt_cnt != '0);
  assign w_in_range = ({1'b0, w_head_id} < SLV_AMT_L);

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < SLV_AMT; i++) begin
      w_sel[i] = (w_head_id == SLV_ID_W'(i));
    end
  end

  // Out-of-range IDs are a decode-error sink: no slave sees them, beats drain one per cycle.
  assign w_slv_rdy = |(w_sel & sa_WREADY_i);
  assign w_hs      = w_fwd & (w_in_range ? w_slv_rdy : 1'b1);
  assign w_rt_pop  = w_hs & w_head_last;
  assign w_rt_push = dsp_AW_push_i & (~dsp_AW_full_o | w_rt_pop);

  assign sa_WVALID_o = (w_fwd && w_in_range) ? w_sel : '0;
  assign sa_WDATA_o  = {SLV_AMT{w_head_data}};
  assign sa_WLAST_o  = {SLV_AMT{w_head_last}};

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      for (int i = 0; i < 2; i++) r_wb_data[i] <= '0;
      r_wb_last <= '0;
      r_wb_rd   <= 1'b0;
      r_wb_wr   <= 1'b0;
      r_wb_cnt  <= 2'd0;
    end else begin
      if (w_wb_push) begin
        r_wb_data[r_wb_wr] <= m_WDATA_i;
        r_wb_last[r_wb_wr] <= m_WLAST_i;
        r_wb_wr            <= ~r_wb_wr;
      end
      if (w_hs) r_wb_rd <= ~r_wb_rd;
      if (w_wb_push && !w_hs)      r_wb_cnt <= r_wb_cnt + 2'd1;
      else if (!w_wb_push && w_hs) r_wb_cnt <= r_wb_cnt - 2'd1;
    end
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      for (int i = 0; i < ROUTE_DEPTH; i++) r_rt_id[i] <= '0;
      r_rt_rd  <= '0;
      r_rt_wr  <= '0;
      r_rt_cnt <= '0;
    end else begin
      if (w_rt_push) begin
        r_rt_id[r_rt_wr] <= dsp_AW_slv_id_i;
        r_rt_wr          <= r_rt_wr + 1'b1;
      end
      if (w_rt_pop) r_rt_rd <= r_rt_rd + 1'b1;
      if (w_rt_push && !w_rt_pop)      r_rt_cnt <= r_rt_cnt + 1'b1;
      else if (!w_rt_push && w_rt_pop) r_rt_cnt <= r_rt_cnt - 1'b1;
    end
  end

`ifdef DSP_W_LEN_CHK_EN
  logic [LEN_W-1:0] r_rt_len [ROUTE_DEPTH];
  logic [LEN_W-1:0] r_beat_cnt;
  logic             r_len_err;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      for (int i = 0; i < ROUTE_DEPTH; i++) r_rt_len[i] <= '0;
    end else if (w_rt_push) begin
      r_rt_len[r_rt_wr] <= dsp_AW_len_i;
    end
  end

  // Flags a WLAST that arrives early or late relative to AWLEN; routing still follows WLAST.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      if (w_hs) begin
        if (w_head_last) begin
          r_beat_cnt <= '0;
          r_len_err  <= (r_beat_cnt != r_rt_len[r_rt_rd]);
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
          r_len_err  <= (r_beat_cnt == r_rt_len[r_rt_rd]);
        end
      end
    end
  end

  assign w_len_err_o = r_len_err;
`else
  logic w_unused_len;
  assign w_unused_len = ^dsp_AW_len_i;
  assign w_len_err_o  = 1'b0;
`endif

endmodule
